// File: rtl/sum3d_pkg.sv
// rtl/sum3d_pkg.sv - shared types and helpers for the streaming 3-D tensor sum
package sum3d_pkg;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Total width that holds the sum of 2*n elements of elem_w bits without overflow.
  function automatic int sum_width(input int elem_w, input int n);
    return elem_w + 1 + $clog2(n);
  endfunction

  // Zero- or sign-extends the low elem_w bits of elem to the full 64-bit result.
  function automatic logic [63:0] extend(input logic [63:0] elem, input int elem_w,
                                         input bit signed_mode);
    logic [63:0] w_mask;
    logic        w_sign;
    w_mask = ~64'd0 << elem_w;
    w_sign = |(elem & (64'd1 << (elem_w - 1)));
    return (elem & ~w_mask) | ((signed_mode && w_sign) ? w_mask : 64'd0);
  endfunction

endpackage

// File: rtl/sum3d_stream_acc_if.sv
// rtl/sum3d_stream_acc_if.sv - beat input and total output handshakes of the stream accumulator
interface sum3d_stream_acc_if #(
  parameter int ELEM_W = 8,
  parameter int LANES  = 2,
  parameter int SUM_W  = 13,
  parameter int CNT_W  = 3
);

  logic                      in_valid;
  logic                      in_ready;
  logic [LANES*ELEM_W-1:0]   in_a;
  logic [LANES*ELEM_W-1:0]   in_b;
  logic                      out_valid;
  logic                      out_ready;
  logic [SUM_W-1:0]          out_sum;
  logic [CNT_W-1:0]          out_beats;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_sum, out_beats
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_sum, out_beats
  );

endinterface

// File: rtl/sum3d_lane_tree.sv
// rtl/sum3d_lane_tree.sv - balanced adder tree over the 2*LANES extended elements of one beat
module sum3d_lane_tree
  import sum3d_pkg::*;
#(
  parameter int ELEM_W = 8,
  parameter int LANES  = 2,
  parameter int SIGNED = 0,
  parameter int SUM_W  = 13
) (
  input  logic [LANES*ELEM_W-1:0] i_a,
  input  logic [LANES*ELEM_W-1:0] i_b,
  output logic [SUM_W-1:0]        o_sum
);

  localparam int LEAVES = 2 * LANES;
  localparam int LVLS   = $clog2(LEAVES);
  localparam int PAD    = 1 << LVLS;

  // Level 0 holds the leaves (a/b interleaved per lane, zero-padded to a power of two).
  for (genvar l = 0; l <= LVLS; l++) begin : g_lvl
    logic [SUM_W-1:0] w_node [PAD >> l];
    for (genvar k = 0; k < (PAD >> l); k++) begin : g_node
      if (l == 0) begin : g_leaf
        if (k < LEAVES) begin : g_elem
          logic [ELEM_W-1:0] w_elem;
          if (k % 2 == 0) begin : g_a
            assign w_elem = i_a[(k/2)*ELEM_W +: ELEM_W];
          end else begin : g_b
            assign w_elem = i_b[(k/2)*ELEM_W +: ELEM_W];
          end
          assign w_node[k] = SUM_W'(extend(64'(w_elem), ELEM_W, SIGNED != 0));
        end else begin : g_pad
          assign w_node[k] = '0;
        end
      end else begin : g_add
        assign w_node[k] = g_lvl[l-1].w_node[2*k] + g_lvl[l-1].w_node[2*k+1];
      end
    end
  end

  assign o_sum = g_lvl[LVLS].w_node[0];

endmodule

// File: rtl/sum3d_stream_acc.sv
// rtl/sum3d_stream_acc.sv - streaming accumulator emitting sum(a[i]+b[i]) once per D0xD1xD2 tensor
module sum3d_stream_acc
  import sum3d_pkg::*;
#(
  parameter int ELEM_W = 8,
  parameter int D0     = 2,
  parameter int D1     = 3,
  parameter int D2     = 2,
  parameter int LANES  = 2,
  parameter int SIGNED = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  sum3d_stream_acc_if.slave  bus
);

  localparam int N     = D0 * D1 * D2;
  localparam int BEATS = N / LANES;
  localparam int SUM_W = sum_width(ELEM_W, N);
  localparam int CNT_W = $clog2(BEATS + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [CNT_W-1:0] BEATS_V   = CNT_W'(BEATS);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_beat_cnt;
  logic [SUM_W-1:0]   r_acc;
  logic [SUM_W-1:0]   r_s1_sum;
  logic               r_s1_valid;
  logic               r_s1_last;
  logic               r_out_valid;
  logic [SUM_W-1:0]   r_out_sum;
  logic [SUM_W-1:0]   w_lane_sum;
  logic               w_in_ready;
  logic               w_accept;
  logic               w_last_beat;
  logic               w_out_xfer;

  sum3d_lane_tree #(
    .ELEM_W (ELEM_W),
    .LANES  (LANES),
    .SIGNED (SIGNED),
    .SUM_W  (SUM_W)
  ) u_lane_tree (
    .i_a    (bus.in_a),
    .i_b    (bus.in_b),
    .o_sum  (w_lane_sum)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = (r_state == ACCUM);
    w_accept    = bus.in_valid && w_in_ready && !flush;
    w_last_beat = w_accept && (r_beat_cnt == LAST_BEAT);
    w_out_xfer  = r_out_valid && bus.out_ready;
    case (r_state)
      ACCUM:   if (w_last_beat) w_state_nxt = DRAIN;
      DRAIN:   w_state_nxt = HOLD;
      HOLD:    if (w_out_xfer) w_state_nxt = ACCUM;
      default: w_state_nxt = ACCUM;
    endcase
    if (flush) w_state_nxt = ACCUM;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ACCUM;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_beat_cnt  <= '0;
      r_acc       <= '0;
      r_s1_sum    <= '0;
      r_s1_valid  <= 1'b0;
      r_s1_last   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
    end else if (flush) begin
      r_beat_cnt  <= '0;
      r_acc       <= '0;
      r_s1_valid  <= 1'b0;
      r_s1_last   <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_s1_valid <= w_accept;
      r_s1_last  <= w_last_beat;
      if (w_accept) begin
        r_s1_sum   <= w_lane_sum;
        r_beat_cnt <= w_last_beat ? '0 : r_beat_cnt + 1'b1;
      end
      if (r_s1_valid) r_acc <= r_acc + r_s1_sum;
      // The last beat is still in S1 during DRAIN, so the total folds it in directly.
      if (r_state == DRAIN && r_s1_last) begin
        r_out_sum   <= r_acc + r_s1_sum;
        r_out_valid <= 1'b1;
      end
      if (w_out_xfer) begin
        r_out_valid <= 1'b0;
        r_acc       <= '0;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_sum   = r_out_sum;
  assign bus.out_beats = (r_state == ACCUM) ? r_beat_cnt : BEATS_V;

endmodule

// File: tb/tb_sum3d_stream_acc.sv
// tb/tb_sum3d_stream_acc.sv - self-checking bench for sum3d_stream_acc (unsigned, signed, 4-lane builds)
module tb_sum3d_stream_acc;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  sum3d_stream_acc_if #(.ELEM_W(8), .LANES(2), .SUM_W(13), .CNT_W(3)) bus ();
  sum3d_stream_acc_if #(.ELEM_W(8), .LANES(2), .SUM_W(13), .CNT_W(3)) bus_s ();
  sum3d_stream_acc_if #(.ELEM_W(8), .LANES(4), .SUM_W(12), .CNT_W(2)) bus4 ();

  // The signed build runs in lockstep on the same stimulus as the unsigned one.
  assign bus_s.in_valid  = bus.in_valid;
  assign bus_s.in_a      = bus.in_a;
  assign bus_s.in_b      = bus.in_b;
  assign bus_s.out_ready = bus.out_ready;

  sum3d_stream_acc #(.ELEM_W(8), .D0(2), .D1(3), .D2(2), .LANES(2), .SIGNED(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus));
  sum3d_stream_acc #(.ELEM_W(8), .D0(2), .D1(3), .D2(2), .LANES(2), .SIGNED(1)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus_s));
  sum3d_stream_acc #(.ELEM_W(8), .D0(2), .D1(2), .D2(2), .LANES(4), .SIGNED(0)) u_dut_l4 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus4));

  typedef struct {
    logic [7:0]  a_base;
    logic [7:0]  a_step;
    logic [7:0]  b_base;
    logic [7:0]  b_step;
    logic [12:0] exp_u;
    logic [12:0] exp_s;
  } vec_t;

  typedef struct {
    logic [12:0] u;
    logic [12:0] s;
  } exp_t;

  vec_t       vecs [7];
  exp_t       sb [$];
  logic [7:0] ta [12];
  logic [7:0] tb [12];
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected actual=%0h required=no_output", bus.out_sum);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sum_unsigned", bus.out_sum, e.u);
        check("sum_signed", bus_s.out_sum, e.s);
        check("valid_signed", bus_s.out_valid, 1);
      end
    end
  end

  task automatic send_beat(input logic [15:0] a, input logic [15:0] b, input int exp_cnt);
    bit ok;
    int n;
    ok = 1'b0;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_a = a;
    bus.in_b = b;
    do begin
      @(negedge clk);
      ok = bus.in_ready;
      if (ok) check("out_beats", bus.out_beats, exp_cnt);
      @(posedge clk); #1;
      n++;
    end while (!ok && n < 200);
    check("beat_accept", ok, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_tensor(input int idx, input bit gaps, input bit push);
    for (int i = 0; i < 12; i++) begin
      ta[i] = 8'(vecs[idx].a_base + vecs[idx].a_step * i);
      tb[i] = 8'(vecs[idx].b_base + vecs[idx].b_step * i);
    end
    if (push) sb.push_back('{vecs[idx].exp_u, vecs[idx].exp_s});
    for (int j = 0; j < 6; j++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send_beat({ta[2*j+1], ta[2*j]}, {tb[2*j+1], tb[2*j]}, j);
    end
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    while (!bus.out_valid && n < 50) begin @(negedge clk); n++; end
    check("out_valid_wait", bus.out_valid, 1);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin @(posedge clk); #1; n++; end
    check("sb_drained", sb.size(), 0);
  endtask

  initial begin
    int n;
    int acc_cnt;
    vecs[0] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 13'h17E8, 13'h1FE8};
    vecs[1] = '{8'h00, 8'h01, 8'h00, 8'h02, 13'd198,  13'd198};
    vecs[2] = '{8'h80, 8'h00, 8'h80, 8'h00, 13'h0C00, 13'h1400};
    vecs[3] = '{8'h7F, 8'h00, 8'h80, 8'h00, 13'd3060, 13'h1FF4};
    vecs[4] = '{8'h01, 8'h00, 8'h01, 8'h00, 13'd24,   13'd24};
    vecs[5] = '{8'h00, 8'h00, 8'h00, 8'h00, 13'd0,    13'd0};
    vecs[6] = '{8'hF0, 8'h03, 8'h10, 8'h0F, 13'd2724, 13'd164};

    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b1;
    bus4.in_valid = 1'b0; bus4.in_a = '0; bus4.in_b = '0; bus4.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_sum", bus.out_sum, 0);
    check("rst_out_beats", bus.out_beats, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_l4_in_ready", bus4.in_ready, 1);
    @(posedge clk); #1;

    // Back-to-back all-ones-byte tensor: total appears exactly two cycles after the last beat.
    send_tensor(0, 1'b0, 1'b1);
    @(negedge clk);
    check("drain_out_valid", bus.out_valid, 0);
    check("drain_in_ready", bus.in_ready, 0);
    check("drain_out_beats", bus.out_beats, 6);
    @(posedge clk); #1;
    @(negedge clk);
    check("lat2_out_valid", bus.out_valid, 1);
    check("lat2_out_sum", bus.out_sum, 13'h17E8);
    @(posedge clk); #1;

    for (int v = 1; v < 7; v++) send_tensor(v, 1'b1, 1'b1);
    drain();

    // Backpressure: total held stable, input blocked, next tensor only after handshake.
    bus.out_ready = 1'b0;
    send_tensor(2, 1'b0, 1'b1);
    wait_out();
    bus.in_valid = 1'b1; bus.in_a = 16'hAAAA; bus.in_b = 16'h5555;
    repeat (10) begin
      @(negedge clk);
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_out_sum", bus.out_sum, 13'h0C00);
      check("bp_in_ready", bus.in_ready, 0);
      check("bp_out_beats", bus.out_beats, 6);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("hs_in_ready", bus.in_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("post_hs_in_ready", bus.in_ready, 1);
    check("post_hs_out_valid", bus.out_valid, 0);
    @(posedge clk); #1;
    send_tensor(3, 1'b0, 1'b1);
    drain();

    // Flush after three beats with a fourth beat presented in the flush cycle.
    for (int j = 0; j < 3; j++) send_beat(16'h0101, 16'h0101, j);
    flush = 1'b1; bus.in_valid = 1'b1; bus.in_a = 16'h0101; bus.in_b = 16'h0101;
    @(posedge clk); #1;
    flush = 1'b0; bus.in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_beats", bus.out_beats, 0);
    check("flush_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    send_tensor(4, 1'b0, 1'b1);
    drain();

    // Flush in HOLD drops the pending total.
    bus.out_ready = 1'b0;
    send_tensor(4, 1'b0, 1'b0);
    wait_out();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("hold_flush_out_valid", bus.out_valid, 0);
    check("hold_flush_in_ready", bus.in_ready, 1);
    check("hold_flush_out_beats", bus.out_beats, 0);
    @(posedge clk); #1;

    // Flush together with out_ready in HOLD: the transfer still completes.
    send_tensor(1, 1'b0, 1'b1);
    wait_out();
    flush = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_xfer_out_valid", bus.out_valid, 0);
    check("flush_xfer_in_ready", bus.in_ready, 1);
    check("flush_xfer_sb", sb.size(), 0);
    @(posedge clk); #1;

    // Reset mid-tensor, then reset while holding a total.
    send_beat(16'h0303, 16'h0303, 0);
    send_beat(16'h0303, 16'h0303, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid_out_valid", bus.out_valid, 0);
    check("rst_mid_out_sum", bus.out_sum, 0);
    check("rst_mid_out_beats", bus.out_beats, 0);
    check("rst_mid_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    send_tensor(0, 1'b0, 1'b0);
    wait_out();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_hold_out_valid", bus.out_valid, 0);
    check("rst_hold_out_sum", bus.out_sum, 0);
    check("rst_hold_out_sum_s", bus_s.out_sum, 0);
    check("rst_hold_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    send_tensor(6, 1'b1, 1'b1);
    drain();

    // Four-lane build: two beats of ones.
    bus4.in_valid = 1'b1; bus4.in_a = 32'h01010101; bus4.in_b = 32'h01010101;
    n = 0;
    acc_cnt = 0;
    while (acc_cnt < 2 && n < 20) begin
      @(negedge clk);
      if (bus4.in_ready) acc_cnt++;
      @(posedge clk); #1;
      n++;
    end
    bus4.in_valid = 1'b0;
    check("l4_beats", acc_cnt, 2);
    n = 0;
    while (!bus4.out_valid && n < 20) begin @(negedge clk); n++; end
    check("l4_out_valid", bus4.out_valid, 1);
    check("l4_out_sum", bus4.out_sum, 16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
